fifo_sync_param: RTL and testbench

//  Single-clock parametrised FIFO, successor to the 8x32 audio sample FIFO in the I2S datapath.

---
 rtl/fifo_sync_param_if.sv | 30 +++
 rtl/fifo_sync_param.sv | 121 ++++++++++++
 tb/tb_fifo_sync_param.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fifo_sync_param_if.sv
// Handshake/status bundle for fifo_sync_param: the producer/consumer side drives
// the master modport, the FIFO itself takes the slave modport.
interface fifo_sync_param_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 3
);
   logic             clear;
   logic             fill;
   logic             drain;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
   logic [AW:0]      depth;
   logic [AW:0]      count;
   logic             full;
   logic             empty;
   logic             afull;
   logic             aempty;
   logic             ovf;
   logic             udf;

   modport master (
      output clear, fill, drain, d, depth,
      input  q, count, full, empty, afull, aempty, ovf, udf
   );

   modport slave (
      input  clear, fill, drain, d, depth,
      output q, count, full, empty, afull, aempty, ovf, udf
   );
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock first-word-fall-through FIFO with runtime depth limit and level flags.
// Optional sticky overflow/underflow flags are built when FIFO_STICKY_ERR_EN is defined.
module fifo_sync_param #(
   parameter int WIDTH     = 32,
   parameter int AW        = 3,
   parameter int AF_MARGIN = 1,
   parameter int AE_LEVEL  = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   fifo_sync_param_if.slave      io_bus
);
   localparam int              DEPTH   = 1 << AW;
   localparam logic [AW:0]     DEPTH_W = DEPTH[AW:0];
   localparam logic [AW:0]     AF_W    = AF_MARGIN[AW:0];
   localparam logic [AW:0]     AE_W    = AE_LEVEL[AW:0];
   localparam logic [AW:0]     ZERO_W  = {(AW+1){1'b0}};
   localparam logic [AW:0]     CNT_ONE = (AW+1)'(1'b1);
   localparam logic [AW-1:0]   PTR_ONE = AW'(1'b1);
   localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;

   logic [AW:0]      w_eff_depth;
   logic [AW:0]      w_free;
   logic [AW:0]      w_count_next;
   logic             w_full;
   logic             w_empty;
   logic             w_fill_acc;
   logic             w_drain_acc;
   logic             w_flush;

   // Zero or out-of-range depth requests fall back to the physical depth.
   always_comb begin
      w_eff_depth = DEPTH_W;
      if ((io_bus.depth != ZERO_W) && (io_bus.depth <= DEPTH_W)) begin
         w_eff_depth = io_bus.depth;
      end else begin
         w_eff_depth = DEPTH_W;
      end
   end

   assign w_flush     = i_rst | io_bus.clear;
   assign w_empty     = (r_count == ZERO_W);
   assign w_full      = (r_count >= w_eff_depth);
   // Count can exceed a freshly lowered depth, so free space saturates at zero.
   assign w_free      = w_full ? ZERO_W : (w_eff_depth - r_count);
   assign w_drain_acc = io_bus.drain & ~w_empty;
   assign w_fill_acc  = io_bus.fill & (~w_full | w_drain_acc);

   // Next occupancy from the accepted push/pop pair.
   always_comb begin
      w_count_next = r_count;
      case ({w_fill_acc, w_drain_acc})
         2'b10:   w_count_next = r_count + CNT_ONE;
         2'b01:   w_count_next = r_count - CNT_ONE;
         default: w_count_next = r_count;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge i_clk) begin
      if (w_flush) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_count  <= ZERO_W;
      end else begin
         if (w_fill_acc) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end else begin
            r_wr_ptr <= r_wr_ptr;
         end
         if (w_drain_acc) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end else begin
            r_rd_ptr <= r_rd_ptr;
         end
         r_count <= w_count_next;
      end
   end

   // Storage array; intentionally left unreset.
   always_ff @(posedge i_clk) begin
      if (!w_flush && w_fill_acc) begin
         r_mem[r_wr_ptr] <= io_bus.d;
      end
   end

   assign io_bus.q      = w_empty ? DATA_ZERO : r_mem[r_rd_ptr];
   assign io_bus.count  = r_count;
   assign io_bus.full   = w_full;
   assign io_bus.empty  = w_empty;
   assign io_bus.afull  = (w_free <= AF_W);
   assign io_bus.aempty = (r_count <= AE_W);

`ifdef FIFO_STICKY_ERR_EN
   logic r_ovf;
   logic r_udf;

   // Refused requests latch until the FIFO is reset or flushed.
   always_ff @(posedge i_clk) begin
      if (w_flush) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         r_ovf <= r_ovf | (io_bus.fill & ~w_fill_acc);
         r_udf <= r_udf | (io_bus.drain & ~w_drain_acc);
      end
   end

   assign io_bus.ovf = r_ovf;
   assign io_bus.udf = r_udf;
`else
   assign io_bus.ovf = 1'b0;
   assign io_bus.udf = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Randomised scoreboard bench for fifo_sync_param against a queue-based reference model.
module tb_fifo_sync_param;
   localparam int WIDTH = 32;
   localparam int AW    = 3;
   localparam int DEPTH = 8;
   localparam int AF    = 1;
   localparam int AE    = 1;
`ifdef FIFO_STICKY_ERR_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fifo_sync_param_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

   fifo_sync_param #(.WIDTH(WIDTH), .AW(AW), .AF_MARGIN(AF), .AE_LEVEL(AE)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .io_bus(bus)
   );

   typedef struct packed {
      logic [31:0] q;
      logic [3:0]  count;
      logic        full;
      logic        empty;
      logic        afull;
      logic        aempty;
      logic        ovf;
      logic        udf;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mdl[$];
   bit          m_ovf = 1'b0;
   bit          m_udf = 1'b0;
   bit          armed = 1'b0;
   int          n_vec = 0;
   int          n_err = 0;
   exp_t        mon_e;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   // One clock of stimulus: record expected pre-edge outputs, then advance the model.
   task automatic cyc(input bit r, input bit c, input bit f, input bit dr,
                      input logic [31:0] din, input logic [3:0] dep);
      exp_t e;
      int   eff, cnt, free;
      bit   dacc, facc;
      rst = r; bus.clear = c; bus.fill = f; bus.drain = dr; bus.d = din; bus.depth = dep;
      eff  = (dep == 0 || dep > DEPTH) ? DEPTH : int'(dep);
      cnt  = mdl.size();
      free = (cnt >= eff) ? 0 : eff - cnt;
      if (armed) begin
         e.q      = (cnt == 0) ? 32'h0 : mdl[0];
         e.count  = 4'(cnt);
         e.full   = (cnt >= eff);
         e.empty  = (cnt == 0);
         e.afull  = (free <= AF);
         e.aempty = (cnt <= AE);
         e.ovf    = m_ovf;
         e.udf    = m_udf;
         sb.push_back(e);
      end
      if (r || c) begin
         mdl.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         dacc = dr && (cnt > 0);
         facc = f && ((cnt < eff) || dacc);
         if (STICKY && f && !facc) m_ovf = 1'b1;
         if (STICKY && dr && !dacc) m_udf = 1'b1;
         if (dacc) void'(mdl.pop_front());
         if (facc) mdl.push_back(din);
      end
      if (r) armed = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare DUT outputs against the oldest expectation each cycle.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         n_vec++;
         chk("q",      bus.q,               mon_e.q);
         chk("count",  32'(bus.count),      32'(mon_e.count));
         chk("full",   32'(bus.full),       32'(mon_e.full));
         chk("empty",  32'(bus.empty),      32'(mon_e.empty));
         chk("afull",  32'(bus.afull),      32'(mon_e.afull));
         chk("aempty", 32'(bus.aempty),     32'(mon_e.aempty));
         chk("ovf",    32'(bus.ovf),        32'(mon_e.ovf));
         chk("udf",    32'(bus.udf),        32'(mon_e.udf));
      end
   end

   initial begin
      logic [3:0] dep;
      bit         f, dr;
      // reset and idle
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0);
      repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0);
      // fill to full, drain to empty
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'hA0 + 32'(i), 4'd0);
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 4'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0);
      // pass-through at full
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'hC0 + 32'(i), 4'd0);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'hB0, 4'd0);
      for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 4'd0);
      // runtime depth 3, refused fills and drains on empty
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'hD0 + 32'(i), 4'd3);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 4'd3);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 4'd3);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0);
      // wrap with occupancy kept between 1 and 6
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'hE000, 4'd0);
      for (int i = 1; i <= 40; i++) begin
         if (mdl.size() <= 1)      begin f = 1'b1; dr = 1'b0; end
         else if (mdl.size() >= 6) begin f = 1'b0; dr = 1'b1; end
         else begin f = 1'($urandom_range(0, 1)); dr = ~f; end
         cyc(1'b0, 1'b0, f, dr, 32'hE000 + 32'(i), 4'd0);
      end
      // clear with simultaneous fill/drain, then reset mid-burst
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'hF0 + 32'(i), 4'd0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'hFF, 4'd0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h1F0 + 32'(i), 4'd0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h1FF, 4'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 4'd0);
      // random traffic with changing depth limits
      dep = 4'd0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 31) == 0) dep = 4'($urandom_range(0, 15));
         cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 79) == 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, dep);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, dep);
      repeat (3) @(negedge clk);
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain_sb: got %0d pending, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
